ws2812_strip: RTL

Parametrised WS2812/SK6812 strip driver: serialises a frame of `NUM_LEDS` pixels of `COLOR_BITS` each, MSB-first, onto a single NRZ data line, then holds the line low for the latch interval. Pixel data is pulled from an external synchronous pixel RAM through an address/data port, one word per LED, so the same block drives anything from a single status LED to a matrix. It sits between the LED frame-buffer logic and the board's LED data pin, with `start`/`busy`/`done` toward the controller.

---
 rtl/ws2812_pkg.sv | 32 +++
 rtl/ws2812_bit_tx.sv | 76 +++++++
 rtl/ws2812_strip.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: state encoding and timing helpers
// shared by the WS2812/SK6812 strip driver.
package ws2812_pkg;

    typedef enum logic [2:0] {
        ST_LATCH,
        ST_IDLE,
        ST_FETCH,
        ST_HIGH,
        ST_LOW
    } state_e;

    localparam int DEF_CLK_FRE  = 27_000_000;
    localparam int DEF_T0H_NS   = 400;
    localparam int DEF_T0L_NS   = 850;
    localparam int DEF_T1H_NS   = 850;
    localparam int DEF_T1L_NS   = 400;
    localparam int DEF_RESET_US = 80;

    function automatic int ns_to_cyc(input int clk_fre, input int ns);
        longint c;
        c = (longint'(clk_fre) / 1000 * longint'(ns)) / 1_000_000;
        return (c < 1) ? 1 : int'(c);
    endfunction

    function automatic int us_to_cyc(input int clk_fre, input int us);
        longint c;
        c = longint'(clk_fre) / 1_000_000 * longint'(us);
        return (c < 1) ? 1 : int'(c);
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: times one NRZ bit (high phase, then low phase).
// A go in the last low cycle chains the next bit with no gap.
module ws2812_bit_tx #(
    parameter int T0H = 10,
    parameter int T0L = 22,
    parameter int T1H = 22,
    parameter int T1L = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go_i,
    input  logic bit_i,
    output logic dout_o,
    output logic hi_last_o,
    output logic bit_done_o
);

    localparam int MH   = (T0H > T1H) ? T0H : T1H;
    localparam int ML   = (T0L > T1L) ? T0L : T1L;
    localparam int TMAX = (MH > ML) ? MH : ML;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] H0 = CW'(T0H - 1);
    localparam logic [CW-1:0] L0 = CW'(T0L - 1);
    localparam logic [CW-1:0] H1 = CW'(T1H - 1);
    localparam logic [CW-1:0] L1 = CW'(T1L - 1);

    logic          act_q, act_d;
    logic          hi_q, hi_d;
    logic          bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hi_end, lo_end;

    always_comb begin
        hi_end     = bit_q ? H1 : H0;
        lo_end     = bit_q ? L1 : L0;
        act_d      = act_q;
        hi_d       = hi_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q + CW'(1);
        hi_last_o  = act_q && hi_q && (cnt_q == hi_end);
        bit_done_o = act_q && !hi_q && (cnt_q == lo_end);
        if (hi_last_o) begin
            hi_d  = 1'b0;
            cnt_d = '0;
        end else if (bit_done_o) begin
            act_d = 1'b0;
            cnt_d = '0;
        end else if (!act_q) begin
            cnt_d = '0;
        end
        if (go_i) begin
            act_d = 1'b1;
            hi_d  = 1'b1;
            bit_d = bit_i;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= 1'b0;
            hi_q  <= 1'b0;
            bit_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            act_q <= act_d;
            hi_q  <= hi_d;
            bit_q <= bit_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o = hi_q;

endmodule

// File: rtl/ws2812_strip.sv
// ws2812_strip: frame sequencer for a WS2812/SK6812 strip, reading
// pixels from a sync RAM with one-pixel-ahead prefetch.
module ws2812_strip
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int COLOR_BITS = 24,
    parameter int CLK_FRE    = DEF_CLK_FRE,
    parameter int T0H_NS     = DEF_T0H_NS,
    parameter int T0L_NS     = DEF_T0L_NS,
    parameter int T1H_NS     = DEF_T1H_NS,
    parameter int T1L_NS     = DEF_T1L_NS,
    parameter int RESET_US   = DEF_RESET_US,
    parameter int AW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [AW-1:0]         pix_addr,
    input  logic [COLOR_BITS-1:0] pix_data,
    output logic                  dout,
    output logic                  busy,
    output logic                  done
);

    localparam int NR = us_to_cyc(CLK_FRE, RESET_US);
    localparam int LW = $clog2(NR + 1);
    localparam int BW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;

    localparam logic [LW-1:0] NR_LAST  = LW'(NR - 1);
    localparam logic [BW-1:0] MSB_IDX  = BW'(COLOR_BITS - 1);
    localparam logic [AW-1:0] LAST_PIX = AW'(NUM_LEDS - 1);

    state_e                  state_q, state_d;
    logic [LW-1:0]           lcnt_q, lcnt_d;
    logic                    fcnt_q, fcnt_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [AW-1:0]           pix_q, pix_d;
    logic [COLOR_BITS-1:0]   shift_q, shift_d;
    logic [COLOR_BITS-1:0]   hold_q, hold_d;
    logic [COLOR_BITS-1:0]   next_word;
    logic [BW-1:0]           bidx_q, bidx_d;
    logic [1:0]              pf_q, pf_d;
    logic                    frame_q, frame_d;
    logic                    go, tx_bit, hi_last, bit_done;

    ws2812_bit_tx #(
        .T0H(ns_to_cyc(CLK_FRE, T0H_NS)),
        .T0L(ns_to_cyc(CLK_FRE, T0L_NS)),
        .T1H(ns_to_cyc(CLK_FRE, T1H_NS)),
        .T1L(ns_to_cyc(CLK_FRE, T1L_NS))
    ) u_bit_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .go_i      (go),
        .bit_i     (tx_bit),
        .dout_o    (dout),
        .hi_last_o (hi_last),
        .bit_done_o(bit_done)
    );

    // pf_q==1 marks the edge where the prefetched word is on pix_data
    always_comb begin
        state_d   = state_q;
        lcnt_d    = lcnt_q;
        fcnt_d    = fcnt_q;
        addr_d    = addr_q;
        pix_d     = pix_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        bidx_d    = bidx_q;
        frame_d   = frame_q;
        pf_d      = (pf_q != 2'd0) ? pf_q - 2'd1 : 2'd0;
        next_word = (pf_q == 2'd1) ? pix_data : hold_q;
        go        = 1'b0;
        tx_bit    = shift_q[COLOR_BITS-1];
        done      = 1'b0;
        if (pf_q == 2'd1) hold_d = pix_data;
        unique case (state_q)
            ST_LATCH: begin
                if (lcnt_q == NR_LAST) begin
                    lcnt_d  = '0;
                    done    = frame_q;
                    frame_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            ST_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    pix_d   = '0;
                    fcnt_d  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fcnt_q) begin
                    fcnt_d = 1'b1;
                end else begin
                    fcnt_d  = 1'b0;
                    shift_d = pix_data;
                    bidx_d  = MSB_IDX;
                    go      = 1'b1;
                    tx_bit  = pix_data[COLOR_BITS-1];
                    state_d = ST_HIGH;
                    if (NUM_LEDS > 1) begin
                        addr_d = pix_q + AW'(1);
                        pf_d   = 2'd2;
                    end
                end
            end
            ST_HIGH: begin
                if (hi_last) state_d = ST_LOW;
            end
            ST_LOW: begin
                if (bit_done) begin
                    if (bidx_q != '0) begin
                        bidx_d  = bidx_q - BW'(1);
                        shift_d = shift_q << 1;
                        go      = 1'b1;
                        tx_bit  = shift_d[COLOR_BITS-1];
                        state_d = ST_HIGH;
                    end else if (pix_q != LAST_PIX) begin
                        pix_d   = pix_q + AW'(1);
                        shift_d = next_word;
                        bidx_d  = MSB_IDX;
                        go      = 1'b1;
                        tx_bit  = next_word[COLOR_BITS-1];
                        state_d = ST_HIGH;
                        if (pix_d != LAST_PIX) begin
                            addr_d = pix_d + AW'(1);
                            pf_d   = 2'd2;
                        end
                    end else begin
                        lcnt_d  = '0;
                        frame_d = 1'b1;
                        state_d = ST_LATCH;
                    end
                end
            end
            default: state_d = ST_LATCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LATCH;
            lcnt_q  <= '0;
            fcnt_q  <= 1'b0;
            addr_q  <= '0;
            pix_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            bidx_q  <= '0;
            pf_q    <= 2'd0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            fcnt_q  <= fcnt_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            bidx_q  <= bidx_d;
            pf_q    <= pf_d;
            frame_q <= frame_d;
        end
    end

    assign pix_addr = addr_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
